inst_fetch_fifo: RTL and testbench
==================================

Name: inst_fetch_fifo

Overview:
- Instruction prefetch queue between the IF-stage instruction-SRAM response path and the ID stage.
- Buffers fetched {pc, inst} pairs and tracks outstanding fetch requests.
- On a CP0 flush, discards every buffered entry and every late response.
- Drives stallreq_for_fifo into the pipeline controller when ID has nothing to consume.

Parameters:
- DEPTH, 8, number of entries; power of two, minimum 2.
- MAX_OUTSTANDING, 4, maximum fetch requests in flight; power of two.
- INST_W, 32, instruction width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush from the controller; new_pc is handled by IF
- req_issue  in  1  IF issued a fetch request this cycle
- req_ready  out  1  IF may issue a request: outstanding + count < DEPTH and outstanding < MAX_OUTSTANDING
- resp_valid  in  1  instruction-SRAM response valid
- resp_pc  in  32  PC of the response
- resp_inst  in  INST_W  instruction data
- id_stall  in  1  ID cannot accept this cycle (stall[1] from the controller)
- pop_valid  out  1  head entry valid to ID
- pop_pc  out  32  head PC
- pop_inst  out  INST_W  head instruction
- stallreq_for_fifo  out  1  queue empty, request front-end stall
- count  out  log2(DEPTH)+1  occupancy

Behaviour:
Storage and pointers:
- Circular buffer; rd_ptr and wr_ptr are log2(DEPTH)+1 bits, wrap naturally.
- empty = pointers equal; full = index bits equal and MSBs differ.
- Reset: pointers, count, outstanding, discard all 0.
- During rst: pop_valid=0, stallreq_for_fifo=0, req_ready=0.

Push:
- Accepted when resp_valid & discard==0 & ~full.
- A response with discard>0 is dropped and discard decrements.
- resp_valid while full and discard==0 is a protocol error; the bench asserts it never occurs (req_ready guarantees this).

Pop:
- Occurs when pop_valid & ~id_stall; rd_ptr increments.
- Head outputs are combinational from the rd_ptr entry (first-word fall-through).
- Push-to-pop latency is 1 cycle; a push into an empty queue is visible next cycle.
- Simultaneous push and pop: count unchanged. Allowed when full only if the push is legal under req_ready accounting.

Outstanding counter:
- +1 on req_issue, -1 on any response (accepted or dropped); both in the same cycle leaves it unchanged.
- Saturates at MAX_OUTSTANDING.

Flush (takes priority over push and pop in the same cycle):
- Next cycle: rd_ptr=wr_ptr=0, count=0.
- discard = outstanding + req_issue - resp_valid (value at flush cycle).
- outstanding is set to the same value.
- pop_valid is forced 0 in the flush cycle.
- Flush while discard>0 recomputes discard from the current outstanding, never adds to it.

stallreq_for_fifo:
- = empty & ~flush & ~rst, registered-free (combinational).
- The controller produces stall 000001 from it.

Optional Feature:
- Macro: INST_FIFO_BYPASS_EN.
- Defined: when empty and a push is accepted with no flush, resp_pc/resp_inst drive pop_* combinationally and pop_valid=1 that cycle.
  - If ~id_stall, the entry is consumed without being written.
  - If id_stall, it is written normally.
  - stallreq_for_fifo is deasserted in the bypass cycle.
- Undefined: 1-cycle push-to-pop latency as above; the bypass path is absent.

Test Plan:
1. Reset, then 3 req_issue; responses pc=0xBFC00000/04/08, id_stall=0 -> pop order matches, count peaks at 1, stallreq_for_fifo=1 only when empty.
2. id_stall=1, 8 responses -> count=8, req_ready=0; release stall -> 8 pops in order, rd_ptr wraps to 0 with MSB toggled, empty.
3. 3 outstanding + 2 buffered, flush -> next cycle count=0, discard=3; next 3 responses (pc 0x100/104/108) dropped; 4th response pc=0x380 popped.
4. Flush same cycle as req_issue and resp_valid with outstanding=2 -> discard=2.
5. Simultaneous push and pop at count=4 for 10 cycles -> count stays 4, data in order.
6. With INST_FIFO_BYPASS_EN, empty, response pc=0x200 and id_stall=0 -> pop_valid=1 same cycle, count stays 0; without the macro, pop_valid rises next cycle.

Source files
------------

// File: rtl/inst_fetch_fifo_if.sv
// Interface for the instruction prefetch queue: fetch request/response side,
// ID-stage pop side and pipeline-control signals.
interface inst_fetch_fifo_if #(
  parameter int DEPTH  = 8,
  parameter int INST_W = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Handshakes: IF may assert req_issue only in a cycle where req_ready is high;
  // responses (resp_valid) carry no backpressure; an entry leaves the queue in
  // every cycle where pop_valid & ~id_stall; flush overrides everything else.
  logic              flush;
  logic              req_issue;
  logic              req_ready;
  logic              resp_valid;
  logic [31:0]       resp_pc;
  logic [INST_W-1:0] resp_inst;
  logic              id_stall;
  logic              pop_valid;
  logic [31:0]       pop_pc;
  logic [INST_W-1:0] pop_inst;
  logic              stallreq_for_fifo;
  logic [CNT_W-1:0]  count;

  modport master (
    output flush, req_issue, resp_valid, resp_pc, resp_inst, id_stall,
    input  req_ready, pop_valid, pop_pc, pop_inst, stallreq_for_fifo, count
  );

  modport slave (
    input  flush, req_issue, resp_valid, resp_pc, resp_inst, id_stall,
    output req_ready, pop_valid, pop_pc, pop_inst, stallreq_for_fifo, count
  );
endinterface

// File: rtl/inst_fetch_fifo.sv
// Instruction prefetch queue between the I-SRAM response path and ID, with
// outstanding-request tracking and flush discard. Optional same-cycle bypass
// of an empty queue is enabled by defining INST_FIFO_BYPASS_EN.
module inst_fetch_fifo #(
  parameter int DEPTH           = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int INST_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  inst_fetch_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int SW = ((PW > OW) ? PW : OW) + 1;

  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [OW-1:0]     outstanding;
  logic [OW-1:0]     outstanding_nxt;
  logic [OW-1:0]     discard;
  logic [OW-1:0]     discard_nxt;

  logic [31:0]       pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic [AW-1:0]     rd_idx;
  logic [AW-1:0]     wr_idx;
  logic [PW-1:0]     occupancy;
  logic [SW-1:0]     committed;
  logic              empty;
  logic              full;
  logic              discard_zero;
  logic              resp_drop;
  logic              push_acc;
  logic              bypass;
  logic              pop_valid_int;
  logic              pop_fire;
  logic              wr_en;
  logic              rd_en;

  assign rd_idx       = rd_ptr[AW-1:0];
  assign wr_idx       = wr_ptr[AW-1:0];
  assign empty        = (rd_ptr == wr_ptr);
  assign full         = (rd_idx == wr_idx) && (rd_ptr[AW] != wr_ptr[AW]);
  assign occupancy    = wr_ptr - rd_ptr;
  assign discard_zero = (discard == '0);
  assign resp_drop    = bus.resp_valid & ~discard_zero;

  // A full queue can still take a response when the head leaves the same cycle.
  assign push_acc = ~rst & ~bus.flush & bus.resp_valid & discard_zero
                  & (~full | ~bus.id_stall);

`ifdef INST_FIFO_BYPASS_EN
  assign bypass = empty & push_acc;
`else
  assign bypass = 1'b0;
`endif

  assign pop_valid_int = ~rst & ~bus.flush & (~empty | bypass);
  assign pop_fire      = pop_valid_int & ~bus.id_stall;
  // A bypassed response consumed by ID never touches storage.
  assign wr_en         = push_acc & ~(bypass & ~bus.id_stall);
  assign rd_en         = pop_fire & ~bypass;

  // Outstanding requests also reserve slots, so a response always finds room.
  assign committed     = SW'(outstanding) + SW'(occupancy);

  assign bus.req_ready = ~rst
                       & (committed < SW'(DEPTH))
                       & (outstanding < OW'(MAX_OUTSTANDING));
  assign bus.pop_valid = pop_valid_int;
  assign bus.pop_pc    = bypass ? bus.resp_pc   : pc_mem[rd_idx];
  assign bus.pop_inst  = bypass ? bus.resp_inst : inst_mem[rd_idx];
  assign bus.stallreq_for_fifo = ~rst & ~bus.flush & empty & ~bypass;
  assign bus.count     = occupancy;

  always_comb begin
    outstanding_nxt = outstanding;
    if (bus.req_issue && !bus.resp_valid) begin
      if (outstanding != OW'(MAX_OUTSTANDING)) begin
        outstanding_nxt = outstanding + OW'(1);
      end
    end else if (!bus.req_issue && bus.resp_valid && outstanding != '0) begin
      outstanding_nxt = outstanding - OW'(1);
    end
  end

  // Every request still in flight at a flush returns stale data; drop that many.
  always_comb begin
    discard_nxt = discard;
    if (bus.flush) begin
      discard_nxt = outstanding_nxt;
    end else if (resp_drop) begin
      discard_nxt = discard - OW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
      if (bus.flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + PW'(1);
        if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_idx]   <= bus.resp_pc;
      inst_mem[wr_idx] <= bus.resp_inst;
    end
  end
endmodule

// File: tb/tb_inst_fetch_fifo.sv
// Bench for inst_fetch_fifo: directed scenarios plus randomized traffic, all
// checked cycle by cycle against a queue-based reference model.
module tb_inst_fetch_fifo;
  localparam int DEPTH  = 8;
  localparam int MAXO   = 4;
  localparam int INST_W = 32;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int OW     = $clog2(MAXO) + 1;

  logic clk;
  logic rst;

  inst_fetch_fifo_if #(.DEPTH(DEPTH), .INST_W(INST_W)) bus ();

  inst_fetch_fifo #(
    .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .INST_W(INST_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: {pc, inst} entries the queue should hold, oldest first
  logic [63:0] exp_q[$];
  logic [31:0] popped[$];
  int          m_out;
  int          m_discard;
  int          n_checks;
  int          n_pass;
  int          peak;

  logic          obs_pv;
  logic [31:0]   obs_pc;
  logic [CW-1:0] obs_count;
  logic          obs_ready;
  logic [OW-1:0] obs_discard;
  logic [OW-1:0] obs_out;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic bit model_ready();
    return (m_out + exp_q.size() < DEPTH) && (m_out < MAXO);
  endfunction

  function automatic int clamp_out(input int v);
    if (v < 0) return 0;
    if (v > MAXO) return MAXO;
    return v;
  endfunction

  // driver: one clock cycle of stimulus, checked before the edge, model updated after
  task automatic step(input bit fl, input bit iss, input bit rv, input logic [31:0] pc, input bit st);
    logic [31:0] inst;
    bit          empty;
    bit          byp;
    bit          e_pv;
    logic [63:0] head;
    @(negedge clk);
    inst          = $urandom;
    bus.flush     = fl;
    bus.req_issue = iss;
    bus.resp_valid = rv;
    bus.resp_pc   = pc;
    bus.resp_inst = inst;
    bus.id_stall  = st;
    #1;
    empty = (exp_q.size() == 0);
    byp   = 1'b0;
`ifdef INST_FIFO_BYPASS_EN
    byp = empty && rv && (m_discard == 0) && !fl;
`endif
    e_pv = !fl && (!empty || byp);
    head = byp ? {pc, inst} : (empty ? 64'd0 : exp_q[0]);
    check("pop_valid", 64'(bus.pop_valid), 64'(e_pv));
    if (e_pv) begin
      check("pop_pc",   64'(bus.pop_pc),   64'(head[63:32]));
      check("pop_inst", 64'(bus.pop_inst), 64'(head[31:0]));
    end
    check("stallreq", 64'(bus.stallreq_for_fifo), 64'(empty && !fl && !byp));
    check("count",    64'(bus.count),     64'(exp_q.size()));
    check("req_ready", 64'(bus.req_ready), 64'(model_ready()));
    if (rv && m_discard == 0 && st) check("resp_room", 64'(bus.count == CW'(DEPTH)), 64'd0);
    obs_pv      = bus.pop_valid;
    obs_pc      = bus.pop_pc;
    obs_count   = bus.count;
    obs_ready   = bus.req_ready;
    obs_discard = dut.discard;
    obs_out     = dut.outstanding;
    if (int'(bus.count) > peak) peak = int'(bus.count);
    if (bus.pop_valid && !st) popped.push_back(bus.pop_pc);
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
      m_out     = clamp_out(m_out + int'(iss) - int'(rv));
      m_discard = m_out;
    end else begin
      if (e_pv && !st && !byp) void'(exp_q.pop_front());
      if (rv) begin
        if (m_discard > 0) m_discard--;
        else if (!(byp && !st)) exp_q.push_back({pc, inst});
      end
      m_out = clamp_out(m_out + int'(iss) - int'(rv));
    end
  endtask

  task automatic idle(input bit st);
    step(1'b0, 1'b0, 1'b0, 32'd0, st);
  endtask

  task automatic run_random(input int n);
    bit fl, iss, rv, st;
    for (int i = 0; i < n; i++) begin
      fl  = ($urandom_range(0, 24) == 0);
      iss = model_ready() && ($urandom_range(0, 2) != 0);
      rv  = (m_out > 0) && ($urandom_range(0, 2) != 0);
      st  = ($urandom_range(0, 3) == 0);
      step(fl, iss, rv, $urandom & 32'hFFFF_FFFC, st);
    end
  endtask

  initial begin
    int k;
    n_checks = 0; n_pass = 0; m_out = 0; m_discard = 0; peak = 0;
    rst = 1'b1;
    bus.flush = 1'b0; bus.req_issue = 1'b0; bus.resp_valid = 1'b0;
    bus.resp_pc = '0; bus.resp_inst = '0; bus.id_stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pop_valid", 64'(bus.pop_valid), 64'd0);
    check("rst_stallreq",  64'(bus.stallreq_for_fifo), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    rst = 1'b0;

    // 1: three fetches flow straight through
    peak = 0; popped.delete();
    repeat (3) step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 32'hBFC0_0000 + 32'(4 * i), 1'b0);
    repeat (2) idle(1'b0);
`ifdef INST_FIFO_BYPASS_EN
    check("t1_peak", 64'(peak), 64'd0);
`else
    check("t1_peak", 64'(peak), 64'd1);
`endif
    check("t1_npop", 64'(popped.size()), 64'd3);
    for (int i = 0; i < popped.size() && i < 3; i++)
      check("t1_order", 64'(popped[i]), 64'(32'hBFC0_0000 + 32'(4 * i)));

    // 2: fill to DEPTH under stall, then drain and wrap
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    k = 0;
    for (int c = 0; c < 40 && exp_q.size() < DEPTH; c++) begin
      if (m_out > 0) begin
        step(1'b0, model_ready(), 1'b1, 32'h1000 + 32'(4 * k), 1'b1);
        k++;
      end else begin
        step(1'b0, model_ready(), 1'b0, 32'd0, 1'b1);
      end
    end
    idle(1'b1);
    check("t2_count", 64'(obs_count), 64'(DEPTH));
    check("t2_ready", 64'(obs_ready), 64'd0);
    popped.delete();
    repeat (DEPTH) idle(1'b0);
    idle(1'b0);
    check("t2_npop", 64'(popped.size()), 64'(DEPTH));
    for (int i = 0; i < popped.size() && i < DEPTH; i++)
      check("t2_order", 64'(popped[i]), 64'(32'h1000 + 32'(4 * i)));
    check("t2_rd_ptr", 64'(dut.rd_ptr), 64'(DEPTH));
    check("t2_empty", 64'(obs_count), 64'd0);

    // 3: flush with 3 outstanding and 2 buffered
    repeat (4) step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h300, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h304, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    idle(1'b0);
    check("t3_count",   64'(obs_count), 64'd0);
    check("t3_discard", 64'(obs_discard), 64'd3);
    popped.delete();
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h100, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h104, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h108, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h380, 1'b0);
    repeat (2) idle(1'b0);
    check("t3_npop", 64'(popped.size()), 64'd1);
    if (popped.size() > 0) check("t3_pc", 64'(popped[0]), 64'h380);

    // 4: flush together with issue and response, outstanding=2
    repeat (2) step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h500, 1'b0);
    idle(1'b0);
    check("t4_discard", 64'(obs_discard), 64'd2);
    check("t4_out",     64'(obs_out),     64'd2);
    repeat (2) step(1'b0, 1'b0, 1'b1, 32'h504, 1'b0);
    idle(1'b0);
    check("t4_drained", 64'(obs_discard), 64'd0);

    // 5: steady push+pop at count 4
    repeat (4) step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 32'h600 + 32'(4 * i), 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    popped.delete();
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b1, 32'h700 + 32'(4 * i), 1'b0);
      check("t5_count", 64'(obs_count), 64'd4);
    end
    check("t5_npop", 64'(popped.size()), 64'd10);
    for (int i = 0; i < popped.size() && i < 10; i++)
      check("t5_order", 64'(popped[i]),
            64'((i < 4) ? 32'h600 + 32'(4 * i) : 32'h700 + 32'(4 * (i - 4))));
    step(1'b0, 1'b0, 1'b1, 32'h800, 1'b0);
    repeat (6) idle(1'b0);

    // 6: response into an empty queue
    popped.delete();
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h200, 1'b0);
`ifdef INST_FIFO_BYPASS_EN
    check("t6_same_cycle", 64'(obs_pv), 64'd1);
`else
    check("t6_same_cycle", 64'(obs_pv), 64'd0);
`endif
    check("t6_count", 64'(obs_count), 64'd0);
    idle(1'b0);
`ifdef INST_FIFO_BYPASS_EN
    check("t6_next_cycle", 64'(obs_pv), 64'd0);
`else
    check("t6_next_cycle", 64'(obs_pv), 64'd1);
`endif
    check("t6_npop", 64'(popped.size()), 64'd1);
    if (popped.size() > 0) check("t6_pc", 64'(popped[0]), 64'h200);

    // randomized traffic against the model
    run_random(600);
    repeat (12) idle(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
